// File: rtl/ring_buffer_flags.sv
// Single-clock ring buffer with occupancy count, almost-full/empty flags, sticky errors and read strobe.
// Optional build macro RING_BUFFER_OVERWRITE_EN: a write while full in mode 10 overwrites the oldest entry.
module ring_buffer_flags #(
  parameter int REG_WIDTH = 8,
  parameter int PTR_SIZE  = 3,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic [REG_WIDTH-1:0] WData,
  input  logic                 clr_err,
  output logic [REG_WIDTH-1:0] RData,
  output logic                 rvalid,
  output logic                 isEmpty,
  output logic                 isFull,
  output logic                 almostEmpty,
  output logic                 almostFull,
  output logic [PTR_SIZE:0]    count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 2 ** PTR_SIZE;
  localparam logic [PTR_SIZE:0] FULL_CNT = (PTR_SIZE + 1)'(DEPTH);
  localparam logic [PTR_SIZE:0] AF_TH    = (PTR_SIZE + 1)'(DEPTH - AF_MARGIN);
  localparam logic [PTR_SIZE:0] AE_TH    = (PTR_SIZE + 1)'(AE_MARGIN);

  logic [REG_WIDTH-1:0] mem [DEPTH];
  logic [PTR_SIZE-1:0]  wr_ptr;
  logic [PTR_SIZE-1:0]  rd_ptr;

  logic empty;
  logic full;
  logic read_ok;
  logic write_ok;
  logic wr_when_full;
  logic ovw;
  logic ovf_set;
  logic unf_set;

  always_comb begin
    empty        = (count == '0);
    full         = (count == FULL_CNT);
    read_ok      = mode[0] & ~empty;
    wr_when_full = (mode == 2'b10) & full;
`ifdef RING_BUFFER_OVERWRITE_EN
    ovw          = wr_when_full;
`else
    ovw          = 1'b0;
`endif
    // In mode 11 the read frees the slot, so a full buffer still takes the write.
    write_ok     = mode[1] & (~full | mode[0] | ovw);
    ovf_set      = wr_when_full;
    unf_set      = mode[0] & empty;
  end

  always_ff @(posedge clk) begin
    if (!reset && write_ok) begin
      mem[wr_ptr] <= WData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      // An overwrite discards the oldest entry, so the read side advances too.
      if (read_ok || ovw) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (write_ok && !read_ok && !ovw) begin
        count <= count + 1'b1;
      end else if (read_ok && !write_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RData  <= '0;
      rvalid <= 1'b0;
    end else begin
      if (read_ok) begin
        RData <= mem[rd_ptr];
      end
      rvalid <= read_ok;
    end
  end

  // Setting an error wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
    end
  end

  assign isEmpty     = empty;
  assign isFull      = full;
  assign almostFull  = (count >= AF_TH);
  assign almostEmpty = (count <= AE_TH);

endmodule

// File: tb/tb_ring_buffer_flags.sv
// Bench for ring_buffer_flags: directed vector table, hand sequences and random traffic vs a queue model.
module tb_ring_buffer_flags;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [7:0] WData;
  logic       clr_err;
  logic [7:0] RData;
  logic       rvalid, isEmpty, isFull, almostEmpty, almostFull, overflow, underflow;
  logic [3:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  ring_buffer_flags #(.REG_WIDTH(8), .PTR_SIZE(3), .AF_MARGIN(2), .AE_MARGIN(2)) dut (
    .clk(clk), .reset(reset), .mode(mode), .WData(WData), .clr_err(clr_err),
    .RData(RData), .rvalid(rvalid), .isEmpty(isEmpty), .isFull(isFull),
    .almostEmpty(almostEmpty), .almostFull(almostFull), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the registered outputs.
  logic [7:0] q[$];
  logic [7:0] m_rdata;
  logic       m_rvalid, m_ov, m_un;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic [1:0] m, input logic [7:0] d, input logic c);
    int n;
    logic set_ov, set_un;
    if (r) begin
      q.delete();
      m_rdata = 8'h00; m_rvalid = 1'b0; m_ov = 1'b0; m_un = 1'b0;
      return;
    end
    n = q.size();
    set_ov = 1'b0;
    set_un = m[0] && (n == 0);
    m_rvalid = 1'b0;
    if (m[0] && n > 0) begin
      m_rdata  = q.pop_front();
      m_rvalid = 1'b1;
    end
    if (m[1]) begin
      if (n < DEPTH || m[0]) begin
        q.push_back(d);
      end else begin
        set_ov = 1'b1;
`ifdef RING_BUFFER_OVERWRITE_EN
        void'(q.pop_front());
        q.push_back(d);
`endif
      end
    end
    m_ov = set_ov | (m_ov & ~c);
    m_un = set_un | (m_un & ~c);
  endtask

  task automatic check_model();
    chk("count",       32'(count),       32'(q.size()));
    chk("RData",       32'(RData),       32'(m_rdata));
    chk("rvalid",      32'(rvalid),      32'(m_rvalid));
    chk("isEmpty",     32'(isEmpty),     32'(q.size() == 0));
    chk("isFull",      32'(isFull),      32'(q.size() == DEPTH));
    chk("almostEmpty", 32'(almostEmpty), 32'(q.size() <= 2));
    chk("almostFull",  32'(almostFull),  32'(q.size() >= DEPTH - 2));
    chk("overflow",    32'(overflow),    32'(m_ov));
    chk("underflow",   32'(underflow),   32'(m_un));
  endtask

  task automatic step(input logic r, input logic [1:0] m, input logic [7:0] d, input logic c);
    reset = r; mode = m; WData = d; clr_err = c;
    @(posedge clk);
    #1;
    model_update(r, m, d, c);
    check_model();
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] mode;
    logic [7:0] wd;
    logic       clr;
    logic [3:0] e_count;
    logic [7:0] e_rdata;
    logic       e_rvalid;
    logic       e_ov;
    logic       e_un;
  } vec_t;

  vec_t vt[$];

  initial begin
    reset = 1'b1; mode = 2'b00; WData = 8'h00; clr_err = 1'b0;

    // Basic write/read, empty read, clear interactions, mode 11 from empty.
    vt.push_back('{1'b1, 2'b00, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 2'b10, 8'h01, 1'b0, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 2'b10, 8'h02, 1'b0, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 2'b10, 8'h03, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 2'b10, 8'h04, 1'b0, 4'd4, 8'h00, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 2'b01, 8'h00, 1'b0, 4'd3, 8'h01, 1'b1, 1'b0, 1'b0});
    vt.push_back('{1'b0, 2'b01, 8'h00, 1'b0, 4'd2, 8'h02, 1'b1, 1'b0, 1'b0});
    vt.push_back('{1'b0, 2'b01, 8'h00, 1'b0, 4'd1, 8'h03, 1'b1, 1'b0, 1'b0});
    vt.push_back('{1'b0, 2'b01, 8'h00, 1'b0, 4'd0, 8'h04, 1'b1, 1'b0, 1'b0});
    vt.push_back('{1'b0, 2'b01, 8'h00, 1'b0, 4'd0, 8'h04, 1'b0, 1'b0, 1'b1});
    vt.push_back('{1'b0, 2'b00, 8'h00, 1'b1, 4'd0, 8'h04, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 2'b01, 8'h00, 1'b1, 4'd0, 8'h04, 1'b0, 1'b0, 1'b1});
    vt.push_back('{1'b0, 2'b00, 8'h00, 1'b1, 4'd0, 8'h04, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 2'b11, 8'hAA, 1'b0, 4'd1, 8'h04, 1'b0, 1'b0, 1'b1});
    vt.push_back('{1'b0, 2'b01, 8'h00, 1'b0, 4'd0, 8'hAA, 1'b1, 1'b0, 1'b1});

    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].mode, vt[i].wd, vt[i].clr);
      chk($sformatf("tbl%0d_count", i),  32'(count),     32'(vt[i].e_count));
      chk($sformatf("tbl%0d_rdata", i),  32'(RData),     32'(vt[i].e_rdata));
      chk($sformatf("tbl%0d_rvalid", i), 32'(rvalid),    32'(vt[i].e_rvalid));
      chk($sformatf("tbl%0d_ovf", i),    32'(overflow),  32'(vt[i].e_ov));
      chk($sformatf("tbl%0d_unf", i),    32'(underflow), 32'(vt[i].e_un));
    end

    // Fill to full, then one extra write while full.
    step(1'b1, 2'b00, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 2'b10, 8'(8'h10 + i), 1'b0);
      chk($sformatf("fill%0d_almostFull", i), 32'(almostFull), 32'(i >= 5));
    end
    chk("fill_isFull", 32'(isFull), 32'd1);
    step(1'b0, 2'b10, 8'h18, 1'b0);
    chk("extra_write_overflow", 32'(overflow), 32'd1);
    chk("extra_write_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 2'b01, 8'h00, 1'b0);
`ifdef RING_BUFFER_OVERWRITE_EN
      chk($sformatf("drain%0d_rdata", i), 32'(RData), 32'(8'h11 + i));
`else
      chk($sformatf("drain%0d_rdata", i), 32'(RData), 32'(8'h10 + i));
`endif
    end
    chk("drain_isEmpty", 32'(isEmpty), 32'd1);

    // Mode 11 from empty, fill, then sustained read+write across pointer wrap.
    step(1'b1, 2'b00, 8'h00, 1'b0);
    step(1'b0, 2'b11, 8'h40, 1'b0);
    chk("rw_empty_count", 32'(count), 32'd1);
    chk("rw_empty_unf", 32'(underflow), 32'd1);
    step(1'b0, 2'b00, 8'h00, 1'b1);
    for (int i = 1; i < 8; i++) step(1'b0, 2'b10, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 2'b11, 8'(8'h48 + i), 1'b0);
      chk($sformatf("rw%0d_rdata", i), 32'(RData), 32'(8'h40 + i));
      chk($sformatf("rw%0d_count", i), 32'(count), 32'd8);
    end
    chk("rw_no_overflow", 32'(overflow), 32'd0);

    // Reset mid-operation discards stored data.
    for (int i = 0; i < 5; i++) step(1'b0, 2'b10, 8'(8'h70 + i), 1'b0);
    step(1'b1, 2'b10, 8'h99, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rdata", 32'(RData), 32'd0);
    chk("rst_almostEmpty", 32'(almostEmpty), 32'd1);
    step(1'b0, 2'b01, 8'h00, 1'b0);
    chk("rst_read_unf", 32'(underflow), 32'd1);
    chk("rst_read_rvalid", 32'(rvalid), 32'd0);
    chk("rst_read_rdata", 32'(RData), 32'd0);

    // Random traffic against the queue model.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(63) == 0, 2'($urandom_range(3)), 8'($urandom),
           $urandom_range(7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ring_buffer_flags.md
# ring_buffer_flags

Parametrised single-clock ring buffer, the next generation of the team's ring buffer. Adds a simultaneous read+write mode, an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a read-valid strobe. It sits between a byte/word producer and consumer in the same clock domain. Producer and consumer share the 2-bit `mode` command bus.

## Interface
- `REG_WIDTH`, default 8: data word width in bits.
- `PTR_SIZE`, default 3: pointer width. `DEPTH = 2**PTR_SIZE` entries.
- `AF_MARGIN`, default 2: `almostFull` asserts when `count >= DEPTH - AF_MARGIN`. Legal range 0..DEPTH-1.
- `AE_MARGIN`, default 2: `almostEmpty` asserts when `count <= AE_MARGIN`. Legal range 0..DEPTH-1.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `mode` in 2: command. 00 idle, 01 read, 10 write, 11 read+write.
- `WData` in REG_WIDTH: write data, sampled on an accepted write.
- `clr_err` in 1: synchronous clear of `overflow` and `underflow`.
- `RData` out REG_WIDTH: registered read data.
- `rvalid` out 1: one-cycle strobe, high when `RData` was updated at the last edge.
- `isEmpty` out 1: `count == 0`.
- `isFull` out 1: `count == DEPTH`.
- `almostEmpty` out 1: almost-empty flag.
- `almostFull` out 1: almost-full flag.
- `count` out PTR_SIZE+1: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky, a write was rejected or lost.
- `underflow` out 1: sticky, a read was rejected.

## Operation
- State: memory `DEPTH x REG_WIDTH`, `wr_ptr`/`rd_ptr` (PTR_SIZE bits, natural wrap DEPTH-1 -> 0), `count` register (PTR_SIZE+1 bits). Full and empty are derived from `count`, not from pointer compare.
- Acceptance, evaluated per edge on pre-edge `count`:
  - read_ok = mode[0] & (count != 0).
  - write_ok = mode[1] & (count != DEPTH), except in mode 11 when full, where write_ok = 1 because the read frees the slot in the same cycle.
- Write accepted: `mem[wr_ptr] <= WData`, `wr_ptr + 1`.
- Read accepted: `RData <= mem[rd_ptr]`, `rd_ptr + 1`, `rvalid <= 1`. Otherwise `rvalid <= 0` and `RData` holds its value.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Mode 11 when empty: write accepted, read rejected, `underflow` set, `count` becomes 1. Same-cycle write data is never forwarded to `RData`.
- Mode 01 when empty: no state change except `underflow <= 1`.
- Mode 10 when full (macro off): write dropped, `overflow <= 1`.
- Error flags: a set condition wins over `clr_err` in the same cycle. `clr_err` alone clears both flags.
- Flags `isEmpty`, `isFull`, `almostEmpty`, `almostFull` are combinational decodes of the `count` register.

## Timing
- Reset values (applied on the edge with `reset = 1`, overriding all commands):
  - `wr_ptr = rd_ptr = 0`, `count = 0`, `RData = 0`, `rvalid = 0`.
  - `isEmpty = 1`, `isFull = 0`.
  - `almostEmpty = 1`, `almostFull = 0` when `AF_MARGIN < DEPTH`.
  - `overflow = underflow = 0`.
  - Memory contents are not reset.
- Reset mid-operation discards all stored entries. Data written before reset is never returned.
- Read latency is 1 cycle: `mode = 01` sampled at edge N gives `RData` and `rvalid` valid after edge N.
- Flag and `count` changes are visible after the edge that performs the accepted access. There is no lookahead.
- Full throughput: one read and one write per cycle sustained in mode 11.

## Configuration
- `RING_BUFFER_OVERWRITE_EN` defined: a write while full in mode 10 is accepted.
  - Overwrites the oldest entry at `mem[wr_ptr]`, where `wr_ptr == rd_ptr`.
  - Advances both pointers; `count` stays DEPTH.
  - `overflow <= 1` to flag data loss.
- `RING_BUFFER_OVERWRITE_EN` undefined: a write while full in mode 10 is dropped and `overflow <= 1`.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use REG_WIDTH=8, PTR_SIZE=3, AF_MARGIN=2, AE_MARGIN=2.

- Reset, then write 1..4, then read 4 times -> `RData` sequence 1,2,3,4 with `rvalid` high each cycle; `count` goes 4 -> 0; `isEmpty` = 1 at the end; `underflow` = 0.
- Write 8 words (0x10..0x17), then 1 more write of 0x18:
  - `isFull` = 1 and `almostFull` = 1 from count 6.
  - Macro off: `overflow` = 1, and the next 8 reads return 0x10..0x17.
  - Macro on: `overflow` = 1, and the reads return 0x11..0x18.
- Read when empty -> `underflow` = 1, `rvalid` = 0, `RData` unchanged. Then `clr_err` pulse -> `underflow` = 0. `clr_err` asserted together with an empty read -> `underflow` stays 1.
- Mode 11 starting empty -> write accepted, `underflow` = 1, `count` = 1. Fill to 8, then mode 11 for 20 cycles with incrementing data -> `count` stays 8, reads in FIFO order across pointer wrap, no `overflow`.
- Write 5 words, assert `reset` for 1 cycle, then read -> `underflow` = 1; outputs match the reset values.
